// File: rtl/calc_seq_pkg.sv
// Shared constants and port FSM state for calc_req_sequencer.
// Optional response watchdog is enabled by defining CALC_SEQ_TIMEOUT_EN.
package calc_seq_pkg;

  localparam int CMD_NOP = 0;
  localparam int CMD_ADD = 1;
  localparam int CMD_SUB = 2;
  localparam int CMD_LSH = 5;
  localparam int CMD_RSH = 6;

  localparam logic [1:0] RESP_NONE    = 2'd0;
  localparam logic [1:0] RESP_OK      = 2'd1;
  localparam logic [1:0] RESP_ERR     = 2'd2;
  localparam logic [1:0] RESP_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND1,
    ST_SEND2,
    ST_WAIT,
    ST_DONE
  } port_state_e;

endpackage

// File: rtl/calc_seq_port.sv
// One sequencer lane: operation queue, two-cycle request FSM, response capture.
// The WAIT watchdog exists only when CALC_SEQ_TIMEOUT_EN is defined.
module calc_seq_port
  import calc_seq_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int CMD_W          = 4,
  parameter int QUEUE_DEPTH    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              push,
  input  logic [CMD_W-1:0]  push_cmd,
  input  logic [DATA_W-1:0] push_op1,
  input  logic [DATA_W-1:0] push_op2,
  output logic              ready,
  output logic [CMD_W-1:0]  req_cmd,
  output logic [DATA_W-1:0] req_data,
  input  logic [1:0]        resp,
  input  logic [DATA_W-1:0] resp_data,
  input  logic              grant,
  output logic              done_req,
  output logic [1:0]        cap_resp,
  output logic [DATA_W-1:0] cap_data,
  output logic              stray
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int EW = CMD_W + 2 * DATA_W;

  logic [EW-1:0]     q_mem [QUEUE_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              pop;
  logic [CMD_W-1:0]  head_cmd;
  logic [DATA_W-1:0] head_op1, head_op2, op2_q;
  port_state_e       state;
  logic              wd_hit;

  // ready uses pre-pop occupancy, so a full queue refuses even when popping
  assign ready    = (count != (AW+1)'(QUEUE_DEPTH));
  assign pop      = (state == ST_IDLE) && (count != '0);
  assign {head_cmd, head_op1, head_op2} = q_mem[rd_ptr];
  assign done_req = (state == ST_DONE);
  assign stray    = (resp != RESP_NONE) && (state != ST_WAIT);

`ifdef CALC_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  assign wd_hit = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge c_clk) begin
    if (reset || state != ST_WAIT || resp != RESP_NONE || wd_hit) wd_cnt <= '0;
    else                                                      wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge c_clk) begin
    if (push) q_mem[wr_ptr] <= {push_cmd, push_op1, push_op2};
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= ST_IDLE;
      req_cmd  <= '0;
      req_data <= '0;
      op2_q    <= '0;
      cap_resp <= RESP_NONE;
      cap_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      case (state)
        ST_IDLE: if (pop) begin
          req_cmd  <= head_cmd;
          req_data <= head_op1;
          op2_q    <= head_op2;
          state    <= ST_SEND1;
        end
        ST_SEND1: begin
          req_cmd  <= '0;
          req_data <= op2_q;
          state    <= ST_SEND2;
        end
        ST_SEND2: begin
          req_cmd  <= '0;
          req_data <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: if (resp != RESP_NONE) begin
          cap_resp <= resp;
          cap_data <= resp_data;
          state    <= ST_DONE;
        end else if (wd_hit) begin
          cap_resp <= RESP_TIMEOUT;
          cap_data <= '0;
          state    <= ST_DONE;
        end
        ST_DONE: if (grant) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/calc_req_sequencer.sv
// Queued multi-port request sequencer: load demux, per-port lanes, completion arbiter.
// Define CALC_SEQ_TIMEOUT_EN to enable the per-port response watchdog.
module calc_req_sequencer
  import calc_seq_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_W         = 32,
  parameter int CMD_W          = 4,
  parameter int QUEUE_DEPTH    = 8,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int PW            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [PW-1:0]               load_port,
  input  logic [CMD_W-1:0]            load_cmd,
  input  logic [DATA_W-1:0]           load_op1,
  input  logic [DATA_W-1:0]           load_op2,
  output logic [NUM_PORTS*CMD_W-1:0]  req_cmd_out,
  output logic [NUM_PORTS*DATA_W-1:0] req_data_out,
  input  logic [NUM_PORTS*2-1:0]      out_resp,
  input  logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic                        done_valid,
  input  logic                        done_ready,
  output logic [PW-1:0]               done_port,
  output logic [1:0]                  done_resp,
  output logic [DATA_W-1:0]           done_data,
  output logic                        err_stray
);
  logic [NUM_PORTS-1:0]             push, ready, done_req, grant, stray;
  logic [NUM_PORTS-1:0][1:0]        cap_resp;
  logic [NUM_PORTS-1:0][DATA_W-1:0] cap_data;
  logic                             lock_valid;
  logic [PW-1:0]                    lock_port;

  assign load_ready = (int'(load_port) < NUM_PORTS) ? ready[load_port] : 1'b0;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    // NOP loads are acknowledged but never enter the queue
    assign push[p]  = load_valid && load_ready && (load_port == PW'(p)) &&
                      (load_cmd != CMD_W'(CMD_NOP));
    assign grant[p] = done_valid && done_ready && (done_port == PW'(p));

    calc_seq_port #(
      .DATA_W(DATA_W), .CMD_W(CMD_W), .QUEUE_DEPTH(QUEUE_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_port (
      .c_clk(c_clk), .reset(reset),
      .push(push[p]), .push_cmd(load_cmd), .push_op1(load_op1), .push_op2(load_op2),
      .ready(ready[p]),
      .req_cmd(req_cmd_out[p*CMD_W +: CMD_W]), .req_data(req_data_out[p*DATA_W +: DATA_W]),
      .resp(out_resp[p*2 +: 2]), .resp_data(out_data[p*DATA_W +: DATA_W]),
      .grant(grant[p]), .done_req(done_req[p]),
      .cap_resp(cap_resp[p]), .cap_data(cap_data[p]), .stray(stray[p])
    );
  end

  // A stalled grant is locked so a lower port entering DONE cannot steal it
  always_comb begin
    done_valid = 1'b0;
    done_port  = '0;
    if (lock_valid) begin
      done_valid = 1'b1;
      done_port  = lock_port;
    end else begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (done_req[p]) begin
          done_valid = 1'b1;
          done_port  = PW'(p);
        end
      end
    end
    done_resp = done_valid ? cap_resp[done_port] : RESP_NONE;
    done_data = done_valid ? cap_data[done_port] : '0;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_port  <= '0;
      err_stray  <= 1'b0;
    end else begin
      lock_valid <= done_valid && !done_ready;
      lock_port  <= done_port;
      if (|stray) err_stray <= 1'b1;
    end
  end

endmodule
